uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Generic single-clock FIFO: circular buffer, head word readable combinationally.
// Latency: a pushed word is visible at rd_dat on the cycle after the push edge.
// Backpressure: wr_rdy drops when full unless a pop is accepted in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       wr_vld,
    output logic                       wr_rdy,
    input  logic [WIDTH-1:0]           wr_dat,
    output logic                       rd_vld,
    input  logic                       rd_rdy,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign rd_vld  = (count != '0);
    assign do_pop  = rd_vld && rd_rdy;
    // A full FIFO still takes a write when the head leaves on the same edge.
    assign wr_rdy  = !full || do_pop;
    assign do_push = wr_vld && wr_rdy;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// UART receiver with configurable width/parity feeding a FIFO of {payload, framing, parity} entries.
// Latency: head entry visible 2 cycles after the stop-bit sample (PUSH cycle + push edge).
// Backpressure: none on the line; a frame completing while the FIFO is full is dropped and sets overrun_error.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_PERIOD = 10,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          serial_in,
    input  logic                          data_read,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          data_ready,
    output logic                          framing_error,
    output logic                          parity_error,
    output logic                          overrun_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int TW   = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int HALF = BIT_PERIOD / 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_PUSH   = 3'd5;

    typedef struct packed {
        logic [DATA_BITS-1:0] payload;
        logic                 framing;
        logic                 parity;
    } entry_t;

    logic                 sync1;
    logic                 sync2;
    logic                 edge_q;
    logic                 start_edge;
    logic                 rx_bit;

    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 fe_q;
    logic                 pe_q;
    logic                 half_tick;
    logic                 bit_tick;

    entry_t               wr_dat;
    entry_t               rd_dat;
    logic                 wr_vld;
    logic                 wr_rdy;
    logic                 rd_vld;
    logic                 pop_acc;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            edge_q <= 1'b1;
        end else begin
            sync1  <= serial_in;
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    // Edge-qualified start: a line held low never re-arms the receiver.
    assign start_edge = !sync2 && edge_q;
    assign rx_bit     = sync2;
    assign half_tick  = (timer == TW'(HALF - 1));
    assign bit_tick   = (timer == TW'(BIT_PERIOD - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state <= ST_START;
                        timer <= '0;
                    end
                end
                ST_START: begin
                    if (half_tick) begin
                        timer <= '0;
                        if (rx_bit) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            fe_q    <= 1'b0;
                            pe_q    <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        timer   <= '0;
                        shift_q <= {rx_bit, shift_q[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            state <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        timer <= '0;
                        pe_q  <= ((^shift_q) ^ rx_bit) != PARITY_ODD;
                        state <= ST_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        timer <= '0;
                        fe_q  <= !rx_bit;
                        state <= ST_PUSH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_PUSH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign wr_vld         = (state == ST_PUSH);
    assign wr_dat.payload = shift_q;
    assign wr_dat.framing = fe_q;
    assign wr_dat.parity  = pe_q && PARITY_EN;
    assign pop_acc        = data_read && rd_vld;

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .n_rst  (n_rst),
        .wr_vld (wr_vld),
        .wr_rdy (wr_rdy),
        .wr_dat (wr_dat),
        .rd_vld (rd_vld),
        .rd_rdy (data_read),
        .rd_dat (rd_dat),
        .count  (fifo_count)
    );

    // A drop in the same cycle as a pop leaves the flag set.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overrun_error <= 1'b0;
        end else if (wr_vld && !wr_rdy) begin
            overrun_error <= 1'b1;
        end else if (pop_acc) begin
            overrun_error <= 1'b0;
        end
    end

    assign data_ready    = rd_vld;
    assign rx_data       = rd_vld ? rd_dat.payload : '0;
    assign framing_error = rd_vld && rd_dat.framing;
    assign parity_error  = rd_vld && rd_dat.parity;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one default 8N1 instance and one even-parity instance.
module tb_uart_rx_fifo;
    localparam int BP = 10;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       parity_error;
    logic       overrun_error;
    logic [2:0] fifo_count;

    logic       serial_in_p;
    logic       data_read_p;
    logic [7:0] rx_data_p;
    logic       data_ready_p;
    logic       framing_error_p;
    logic       parity_error_p;
    logic       overrun_error_p;
    logic [2:0] fifo_count_p;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_fifo dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .parity_error  (parity_error),
        .overrun_error (overrun_error),
        .fifo_count    (fifo_count)
    );

    uart_rx_fifo #(
        .DATA_BITS  (8),
        .BIT_PERIOD (BP),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0),
        .FIFO_DEPTH (4)
    ) dut_p (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in_p),
        .data_read     (data_read_p),
        .rx_data       (rx_data_p),
        .data_ready    (data_ready_p),
        .framing_error (framing_error_p),
        .parity_error  (parity_error_p),
        .overrun_error (overrun_error_p),
        .fifo_count    (fifo_count_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic to_par);
        if (to_par) serial_in_p = b;
        else        serial_in   = b;
        repeat (BP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] dat, input logic use_par, input logic par_bit,
                              input logic stop_bit, input logic to_par);
        drive_bit(1'b0, to_par);
        for (int i = 0; i < 8; i++) drive_bit(dat[i], to_par);
        if (use_par) drive_bit(par_bit, to_par);
        drive_bit(stop_bit, to_par);
        if (to_par) serial_in_p = 1'b1;
        else        serial_in   = 1'b1;
    endtask

    task automatic pop(input logic to_par);
        if (to_par) data_read_p = 1'b1;
        else        data_read   = 1'b1;
        @(negedge clk);
        data_read   = 1'b0;
        data_read_p = 1'b0;
    endtask

    initial begin
        n_rst       = 1'b0;
        serial_in   = 1'b1;
        serial_in_p = 1'b1;
        data_read   = 1'b0;
        data_read_p = 1'b0;
        idle(3);
        check_eq("rst_ready", 32'(data_ready), 0);
        check_eq("rst_data", 32'(rx_data), 0);
        check_eq("rst_count", 32'(fifo_count), 0);
        check_eq("rst_ovr", 32'(overrun_error), 0);
        check_eq("rst_fe", 32'(framing_error), 0);
        check_eq("rst_pe_p", 32'(parity_error_p), 0);
        n_rst = 1'b1;
        idle(5);

        // Nominal 8N1 frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("nom_ready", 32'(data_ready), 1);
        check_eq("nom_data", 32'(rx_data), 32'hA5);
        check_eq("nom_fe", 32'(framing_error), 0);
        check_eq("nom_count", 32'(fifo_count), 1);
        pop(1'b0);
        check_eq("nom_pop_ready", 32'(data_ready), 0);
        check_eq("nom_pop_data", 32'(rx_data), 0);

        // Framing error, then a clean frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);
        check_eq("fe_data", 32'(rx_data), 32'h3C);
        check_eq("fe_flag", 32'(framing_error), 1);
        pop(1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("fe_next_data", 32'(rx_data), 32'h01);
        check_eq("fe_next_flag", 32'(framing_error), 0);
        pop(1'b0);

        // Even parity on the parity instance: 0x07 has three ones
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(5);
        check_eq("par_count", 32'(fifo_count_p), 2);
        check_eq("par_ok_data", 32'(rx_data_p), 32'h07);
        check_eq("par_ok_pe", 32'(parity_error_p), 0);
        pop(1'b1);
        check_eq("par_bad_data", 32'(rx_data_p), 32'h07);
        check_eq("par_bad_pe", 32'(parity_error_p), 1);
        check_eq("par_bad_fe", 32'(framing_error_p), 0);
        pop(1'b1);

        // False start: 3-cycle glitch
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        idle(2 * BP);
        check_eq("glitch_count", 32'(fifo_count), 0);
        check_eq("glitch_ready", 32'(data_ready), 0);
        check_eq("glitch_idle", 32'(dut.state), 0);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("glitch_next_data", 32'(rx_data), 32'h55);
        check_eq("glitch_next_count", 32'(fifo_count), 1);
        pop(1'b0);

        // Overrun: five back-to-back frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("ovr_count", 32'(fifo_count), 4);
        check_eq("ovr_flag", 32'(overrun_error), 1);
        check_eq("ovr_head", 32'(rx_data), 32'h10);
        pop(1'b0);
        check_eq("ovr_clear", 32'(overrun_error), 0);
        check_eq("ovr_rd1", 32'(rx_data), 32'h11);
        check_eq("ovr_count3", 32'(fifo_count), 3);
        pop(1'b0);
        check_eq("ovr_rd2", 32'(rx_data), 32'h12);
        pop(1'b0);
        check_eq("ovr_rd3", 32'(rx_data), 32'h13);
        pop(1'b0);
        check_eq("ovr_empty", 32'(data_ready), 0);

        // Pointer wrap: pairs of frames, each pair drained
        for (int j = 0; j < 3; j++) begin
            send_frame(8'h20 + 8'(2 * j), 1'b0, 1'b0, 1'b1, 1'b0);
            send_frame(8'h21 + 8'(2 * j), 1'b0, 1'b0, 1'b1, 1'b0);
            idle(5);
            check_eq("wrap_count", 32'(fifo_count), 2);
            check_eq("wrap_a", 32'(rx_data), 32'h20 + 32'(2 * j));
            pop(1'b0);
            check_eq("wrap_b", 32'(rx_data), 32'h21 + 32'(2 * j));
            pop(1'b0);
            check_eq("wrap_drained", 32'(fifo_count), 0);
        end

        // Reset during data bit 3 with one entry already queued
        send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("mid_pre_count", 32'(fifo_count), 1);
        fork
            send_frame(8'hAB, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (44) @(negedge clk);
                n_rst = 1'b0;
                #1;
                check_eq("mid_rst_ready", 32'(data_ready), 0);
                check_eq("mid_rst_count", 32'(fifo_count), 0);
                check_eq("mid_rst_data", 32'(rx_data), 0);
                check_eq("mid_rst_state", 32'(dut.state), 0);
            end
        join
        idle(3);
        n_rst = 1'b1;
        idle(5);
        check_eq("mid_after_count", 32'(fifo_count), 0);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("mid_c3_data", 32'(rx_data), 32'hC3);
        check_eq("mid_c3_count", 32'(fifo_count), 1);
        check_eq("mid_c3_fe", 32'(framing_error), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
